// File: rtl/hex_sched_pkg.sv
// rtl/hex_sched_pkg.sv - shared state encoding, defaults and frame-boundary helper
package hex_sched_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam int DATA_LEN_DEF = 128;
  localparam int FC_W         = 16;

  // Top-left pixel request from the st7735 driver marks the start of a frame.
  function automatic logic is_boundary(input logic next_pixel, input logic [8:0] x,
                                       input logic [7:0] y);
    return next_pixel && (x == 9'd0) && (y == 8'd0);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, search starts at ptr, one-hot grant plus index
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PW-1:0]    idx,
  output logic             valid
);

  logic [N_REQ-1:0] rot;

  // Rotate so that bit 0 of rot is the requester at ptr.
  assign rot = N_REQ'({req, req} >> ptr);

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return PW'(s);
  endfunction

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    // Scan downwards so the lowest rotated position (closest to ptr) wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid = 1'b1;
        idx   = wrap_add(ptr, k);
      end
    end
  end

  assign grant = valid ? (N_REQ'(1) << idx) : '0;

endmodule

// File: rtl/hex_frame_scheduler.sv
// rtl/hex_frame_scheduler.sv - arbitrates display words and commits them to hex_decoder
// HEX_FRAME_SYNC_EN: commit only on a frame boundary; otherwise commit on the edge after grant.
module hex_frame_scheduler
  import hex_sched_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int C_data_len = DATA_LEN_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*C_data_len-1:0] req_data,
  output logic [N_REQ-1:0]            ack,
  input  logic [8:0]                  x,
  input  logic [7:0]                  y,
  input  logic                        next_pixel,
  output logic [C_data_len-1:0]       display,
  output logic                        busy,
  output logic [FC_W-1:0]             frame_count
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t                state, state_next;
  logic [PW-1:0]         ptr, next_ptr, grant_idx;
  logic [N_REQ-1:0]      grant;
  logic                  grant_valid, do_grant, do_commit, boundary;
  logic [C_data_len-1:0] data_buf;

  assign boundary = is_boundary(next_pixel, x, y);
  assign busy     = (state == PENDING);
  assign next_ptr = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;

  rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (grant),
    .idx   (grant_idx),
    .valid (grant_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    do_commit  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          do_grant   = 1'b1;
          state_next = PENDING;
        end
      end
      PENDING: begin
`ifdef HEX_FRAME_SYNC_EN
        do_commit = boundary;
`else
        do_commit = 1'b1;
`endif
        if (do_commit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= '0;
      ack         <= '0;
      data_buf    <= '0;
      display     <= '0;
      frame_count <= '0;
    end else begin
      ack <= do_grant ? grant : '0;
      if (do_grant) begin
        data_buf <= req_data[int'(grant_idx)*C_data_len +: C_data_len];
        ptr      <= next_ptr;
      end
      if (do_commit) display <= data_buf;
      // Counts in every state; wraps naturally at 0xFFFF.
      if (boundary) frame_count <= frame_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hex_frame_scheduler.sv
// tb/tb_hex_frame_scheduler.sv - directed scoreboard bench for hex_frame_scheduler
module tb_hex_frame_scheduler;
  import hex_sched_pkg::*;

  localparam int N = 2;
  localparam int W = DATA_LEN_DEF;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*W-1:0]    req_data;
  logic [N-1:0]      ack;
  logic [8:0]        x;
  logic [7:0]        y;
  logic              next_pixel;
  logic [W-1:0]      display;
  logic              busy;
  logic [FC_W-1:0]   frame_count;

  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] disp_m;
  int          ptr_m;
  int          exp_fc;

  hex_frame_scheduler #(.N_REQ(N), .C_data_len(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .x           (x),
    .y           (y),
    .next_pixel  (next_pixel),
    .display     (display),
    .busy        (busy),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic boundary_tick();
    next_pixel = 1'b1;
    x = 9'd0;
    y = 8'd0;
    tick();
    exp_fc = (exp_fc + 1) & 16'hFFFF;
    next_pixel = 1'b0;
    x = 9'd7;
    y = 8'd3;
  endtask

  task automatic set_data(input int i, input logic [W-1:0] d);
    req_data[i*W +: W] = d;
  endtask

  function automatic int rr_pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr_m + k) % N]) return (ptr_m + k) % N;
    end
    return -1;
  endfunction

  // One full transaction: expect ack from the model's choice, then the commit.
  task automatic serve(input string tag, input bit hold);
    int g;
    int waited;
    g = rr_pick(req);
    exp_q.push_back(req_data[g*W +: W]);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (ack == '0 && waited < 20);
    chk({tag, "_ack"}, W'(ack), W'(N'(1) << g));
    chk({tag, "_busy"}, W'(busy), W'(1'b1));
    chk({tag, "_hold"}, display, disp_m);
    ptr_m = (g + 1) % N;
    if (!hold) req[g] = 1'b0;
`ifdef HEX_FRAME_SYNC_EN
    repeat (3) tick();
    chk({tag, "_wait"}, display, disp_m);
    boundary_tick();
`else
    tick();
`endif
    disp_m = exp_q.pop_front();
    chk({tag, "_done"}, W'(busy), W'(1'b0));
    chk({tag, "_disp"}, display, disp_m);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    req_data = '0;
    x = 9'd7;
    y = 8'd3;
    next_pixel = 1'b0;
    disp_m = '0;
    ptr_m = 0;
    exp_fc = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_display", display, '0);
    chk("rst_fc", W'(frame_count), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_ack", W'(ack), '0);

    // Partial boundaries must not count.
    next_pixel = 1'b1; x = 9'd1; y = 8'd0; tick();
    next_pixel = 1'b1; x = 9'd0; y = 8'd1; tick();
    next_pixel = 1'b0; x = 9'd0; y = 8'd0; tick();
    chk("fc_partial", W'(frame_count), '0);
    repeat (3) boundary_tick();
    chk("fc_three", W'(frame_count), W'(exp_fc));

`ifdef HEX_FRAME_SYNC_EN
    begin
      int busy_cnt;
      set_data(0, W'(16'h1234));
      req = 2'b01;
      exp_q.push_back(W'(16'h1234));
      tick();
      chk("d1234_ack", W'(ack), W'(2'b01));
      req = 2'b00;
      ptr_m = 1;
      tick();
      chk("d1234_ack_pulse", W'(ack), '0);
      busy_cnt = 1;
      repeat (49) begin
        if (busy) busy_cnt++;
        tick();
      end
      chk("d1234_busy50", W'(busy_cnt), W'(50));
      chk("d1234_nocommit", display, '0);
      boundary_tick();
      disp_m = exp_q.pop_front();
      chk("d1234_disp", display, disp_m);
      chk("d1234_idle", W'(busy), '0);
    end

    // Boundary on the grant edge is ignored.
    set_data(1, W'(16'h5151));
    req = 2'b10;
    exp_q.push_back(W'(16'h5151));
    boundary_tick();
    chk("coin_ack", W'(ack), W'(2'b10));
    chk("coin_busy", W'(busy), W'(1'b1));
    chk("coin_nocommit", display, disp_m);
    req = 2'b00;
    ptr_m = 0;
    repeat (4) tick();
    chk("coin_still", display, disp_m);
    boundary_tick();
    disp_m = exp_q.pop_front();
    chk("coin_disp", display, disp_m);
`else
    set_data(1, W'(16'hBEEF));
    req = 2'b10;
    serve("beef", 1'b0);
`endif

    // Both held: round-robin 0,1,0,1.
    set_data(0, {W/8{8'hA5}});
    set_data(1, {W/8{8'h5A}});
    req = 2'b11;
    serve("rr0", 1'b1);
    serve("rr1", 1'b1);
    serve("rr2", 1'b1);
    serve("rr3", 1'b1);
    req = 2'b00;
    tick();
    chk("fc_mid", W'(frame_count), W'(exp_fc));

    // Reset while pending: no commit, pointer back to 0.
    set_data(0, W'(16'hCAFE));
    req = 2'b01;
    tick();
    chk("rstp_ack", W'(ack), W'(2'b01));
    req = 2'b00;
    rst = 1'b1;
    #1;
    chk("rstp_async_busy", W'(busy), '0);
    chk("rstp_async_ack", W'(ack), '0);
    chk("rstp_async_disp", display, '0);
    tick();
    rst = 1'b0;
    disp_m = '0;
    ptr_m = 0;
    exp_fc = 0;
    repeat (2) tick();
    chk("rstp_nocommit", display, '0);
    set_data(0, W'(16'h0A0A));
    set_data(1, W'(16'h1B1B));
    req = 2'b11;
    serve("rstp_g0", 1'b0);
    serve("rstp_g1", 1'b0);
    req = 2'b00;

    // Frame counter wrap.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_fc = 0;
    next_pixel = 1'b1;
    x = 9'd0;
    y = 8'd0;
    repeat (65535) tick();
    chk("fc_ffff", W'(frame_count), W'(16'hFFFF));
    tick();
    chk("fc_wrap", W'(frame_count), '0);
    next_pixel = 1'b0;
    chk("fc_disp", display, '0);
    chk("fc_busy", W'(busy), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
